boreal_vns_interlock: RTL

//  Safety interlock stage directly downstream of the autonomic dysreflexia (AD) guard.
//  It consumes the guard's ad_guard_active flag and gates the VNS stimulation command.
//  On a trip it ramps the amplitude down to 0, then holds a timed lockout. It re-arms

---
 rtl/boreal_vns_interlock.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/boreal_vns_interlock.sv
// -----------------------------------------------------------------------------
// Module: boreal_vns_interlock
//
// Purpose:
//   Safety interlock stage that sits directly after the autonomic dysreflexia
//   (AD) guard. It gates the VNS stimulation command using the guard's
//   ad_guard_active flag. When the guard trips, the amplitude ramps down to
//   zero and a timed lockout follows. Stimulation re-arms only after
//   CLEAR_WINDOWS consecutive clean guard evaluations.
//
// Ports:
//   clk                 in   1      system clock
//   rst                 in   1      asynchronous, active-high reset
//   stim_req_i          in   1      upstream controller requests stimulation
//   stim_amp_req_i      in   AMP_W  requested amplitude (unsigned)
//   ad_guard_active_i   in   1      AD guard interlock flag (level)
//   guard_eval_stb_i    in   1      one-cycle pulse per guard evaluation window
//   fault_ack_i         in   1      clinician acknowledge pulse (optional feature)
//   stim_en_o           out  1      stimulation enable to the VNS driver
//   stim_amp_o          out  AMP_W  gated amplitude
//   il_state_o          out  2      0=ARMED 1=RAMP_DOWN 2=LOCKOUT 3=REARM
//   trip_count_o        out  8      trips since reset, saturating at 255
//
// Configuration macro:
//   VNS_FAULT_ACK_EN - when defined, leaving REARM for ARMED also needs a
//   fault_ack_i pulse seen while in REARM. When undefined, fault_ack_i is
//   ignored.
// -----------------------------------------------------------------------------
module boreal_vns_interlock #(
    parameter int AMP_W          = 12,
    parameter int RAMP_STEP      = 16,
    parameter int TICK_DIV       = 1000,
    parameter int LOCKOUT_CYCLES = 1000000,
    parameter int CLEAR_WINDOWS  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stim_req_i,
    input  logic [AMP_W-1:0] stim_amp_req_i,
    input  logic             ad_guard_active_i,
    input  logic             guard_eval_stb_i,
    input  logic             fault_ack_i,
    output logic             stim_en_o,
    output logic [AMP_W-1:0] stim_amp_o,
    output logic [1:0]       il_state_o,
    output logic [7:0]       trip_count_o
);

    typedef enum logic [1:0] {
        ST_ARMED     = 2'd0,
        ST_RAMP_DOWN = 2'd1,
        ST_LOCKOUT   = 2'd2,
        ST_REARM     = 2'd3
    } state_t;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int CLR_W  = $clog2(CLEAR_WINDOWS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CLR_W-1:0]  CLR_DONE  = CLR_W'(CLEAR_WINDOWS);
    localparam logic [AMP_W:0]    STEP_EXT  = (AMP_W + 1)'(RAMP_STEP);

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tickCnt_q, tickCnt_d;
    logic [LOCK_W-1:0]  lockCnt_q, lockCnt_d;
    logic [CLR_W-1:0]   clearCnt_q, clearCnt_d;
    logic               stimEn_q, stimEn_d;
    logic [AMP_W-1:0]   stimAmp_q, stimAmp_d;
    logic [7:0]         tripCnt_q, tripCnt_d;

    logic [AMP_W-1:0]   rampedAmp;
    logic [7:0]         tripInc;
    logic [CLR_W-1:0]   clearNext;
    logic               ackOk;

`ifdef VNS_FAULT_ACK_EN
    // Acknowledge latch: remembers a fault_ack pulse for the rest of the
    // current REARM visit so the ack may arrive before or after the clean
    // windows are complete.
    logic ackSeen_q, ackSeen_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ackSeen_q <= 1'b0;
        end else begin
            ackSeen_q <= ackSeen_d;
        end
    end

    always_comb begin
        ackSeen_d = 1'b0;
        if (state_q == ST_REARM && state_d == ST_REARM) begin
            ackSeen_d = ackSeen_q | fault_ack_i;
        end
    end

    assign ackOk = ackSeen_q | fault_ack_i;
`else
    logic unused_fault_ack;
    assign unused_fault_ack = fault_ack_i;
    assign ackOk            = 1'b1;
`endif

    // Saturating helpers shared by the trip paths and the ramp step.
    always_comb begin
        rampedAmp = '0;
        if ({1'b0, stimAmp_q} > STEP_EXT) begin
            rampedAmp = stimAmp_q - STEP_EXT[AMP_W-1:0];
        end
        tripInc = (tripCnt_q == 8'hFF) ? tripCnt_q : tripCnt_q + 8'd1;
    end

    // Next-state and registered-output logic for the interlock FSM.
    always_comb begin
        state_d    = state_q;
        tickCnt_d  = tickCnt_q;
        lockCnt_d  = lockCnt_q;
        clearCnt_d = clearCnt_q;
        stimEn_d   = stimEn_q;
        stimAmp_d  = stimAmp_q;
        tripCnt_d  = tripCnt_q;
        clearNext  = clearCnt_q;

        case (state_q)
            ST_ARMED: begin
                if (ad_guard_active_i) begin
                    // Trip wins over the request: amplitude is held so the
                    // ramp starts from what the driver is currently delivering.
                    state_d   = ST_RAMP_DOWN;
                    tickCnt_d = '0;
                    tripCnt_d = tripInc;
                    stimEn_d  = (stimAmp_q != '0);
                end else begin
                    stimEn_d  = stim_req_i;
                    stimAmp_d = stim_req_i ? stim_amp_req_i : '0;
                end
            end

            ST_RAMP_DOWN: begin
                if (stimAmp_q == '0) begin
                    state_d   = ST_LOCKOUT;
                    lockCnt_d = '0;
                    tickCnt_d = '0;
                    stimEn_d  = 1'b0;
                end else if (tickCnt_q == TICK_LAST) begin
                    tickCnt_d = '0;
                    stimAmp_d = rampedAmp;
                    stimEn_d  = (rampedAmp != '0);
                end else begin
                    tickCnt_d = tickCnt_q + 1'b1;
                    stimEn_d  = 1'b1;
                end
            end

            ST_LOCKOUT: begin
                stimEn_d  = 1'b0;
                stimAmp_d = '0;
                // A guard assertion restarts the full lockout period but is
                // not counted as a new trip.
                if (ad_guard_active_i) begin
                    lockCnt_d = '0;
                end else if (lockCnt_q == LOCK_LAST) begin
                    state_d    = ST_REARM;
                    lockCnt_d  = '0;
                    clearCnt_d = '0;
                end else begin
                    lockCnt_d = lockCnt_q + 1'b1;
                end
            end

            ST_REARM: begin
                stimEn_d  = 1'b0;
                stimAmp_d = '0;
                if (guard_eval_stb_i && ad_guard_active_i) begin
                    state_d    = ST_LOCKOUT;
                    lockCnt_d  = '0;
                    clearCnt_d = '0;
                    tripCnt_d  = tripInc;
                end else begin
                    if (guard_eval_stb_i && clearCnt_q != CLR_DONE) begin
                        clearNext = clearCnt_q + 1'b1;
                    end
                    clearCnt_d = clearNext;
                    if (clearNext == CLR_DONE && ackOk) begin
                        state_d    = ST_ARMED;
                        clearCnt_d = '0;
                    end
                end
            end

            default: begin
                state_d   = ST_ARMED;
                stimEn_d  = 1'b0;
                stimAmp_d = '0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately,
    // including a ramp or lockout in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ARMED;
            tickCnt_q  <= '0;
            lockCnt_q  <= '0;
            clearCnt_q <= '0;
            stimEn_q   <= 1'b0;
            stimAmp_q  <= '0;
            tripCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tickCnt_q  <= tickCnt_d;
            lockCnt_q  <= lockCnt_d;
            clearCnt_q <= clearCnt_d;
            stimEn_q   <= stimEn_d;
            stimAmp_q  <= stimAmp_d;
            tripCnt_q  <= tripCnt_d;
        end
    end

    assign stim_en_o    = stimEn_q;
    assign stim_amp_o   = stimAmp_q;
    assign il_state_o   = state_q;
    assign trip_count_o = tripCnt_q;

endmodule
